// File: rtl/data_memory_responder_pkg.sv
// Shared types and default sizes for the data memory responder.
package data_memory_responder_pkg;

    localparam int DEF_D_SIZE = 32;
    localparam int DEF_A_SIZE = 10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Where the registered read data currently comes from.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_WT   = 2'd2
    } rd_src_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// Core data port, host load port and status signals of the data memory responder.
interface data_memory_responder_if #(
    parameter int D_SIZE = 32,
    parameter int A_SIZE = 10
) ();
    logic              read;
    logic              write;
    logic [A_SIZE-1:0] address;
    logic [D_SIZE-1:0] wr_data;
    logic [D_SIZE-1:0] rd_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [A_SIZE-1:0] ld_addr;
    logic [D_SIZE-1:0] ld_data;
    logic              init_done;
    logic              err;
    logic              err_clr;

    modport master (
        output read, write, address, wr_data, ld_valid, ld_addr, ld_data, err_clr,
        input  rd_data, ld_ready, init_done, err
    );

    modport slave (
        input  read, write, address, wr_data, ld_valid, ld_addr, ld_data, err_clr,
        output rd_data, ld_ready, init_done, err
    );
endinterface

// File: rtl/data_memory_responder_mem_array.sv
// Storage array: one write port, one synchronous read port, no reset (maps to block RAM).
module mem_array #(
    parameter int D_SIZE = 32,
    parameter int A_SIZE = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [A_SIZE-1:0] waddr,
    input  logic [D_SIZE-1:0] wdata,
    input  logic              re,
    input  logic [A_SIZE-1:0] raddr,
    output logic [D_SIZE-1:0] rdata
);
    logic [D_SIZE-1:0] mem [2**A_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/data_memory_responder.sv
// Data memory responder: clears the array after reset, then serves core reads/writes
// and host loads, with the core taking priority over the host.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int D_SIZE         = DEF_D_SIZE,
    parameter int A_SIZE         = DEF_A_SIZE,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    data_memory_responder_if.slave  bus
);
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    state_t            state_reg, state_next;
    logic [A_SIZE-1:0] clr_cnt_reg, clr_cnt_next;
    logic              err_reg, err_next;
    rd_src_t           rd_src_reg, rd_src_next;
    logic [D_SIZE-1:0] wt_data_reg, wt_data_next;

    logic              in_clear;
    logic              core_rd;
    logic              core_wr;
    logic              ld_ready;
    logic              err_set;
    logic              mem_we;
    logic              mem_re;
    logic [A_SIZE-1:0] mem_waddr;
    logic [D_SIZE-1:0] mem_wdata;
    logic [D_SIZE-1:0] mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RESET_STATE;
            clr_cnt_reg <= '0;
            err_reg     <= 1'b0;
            rd_src_reg  <= SRC_ZERO;
            wt_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            err_reg     <= err_next;
            rd_src_reg  <= rd_src_next;
            wt_data_reg <= wt_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        rd_src_next  = rd_src_reg;
        wt_data_next = wt_data_reg;
        mem_we       = 1'b0;
        mem_waddr    = bus.address;
        mem_wdata    = bus.wr_data;

        in_clear = (state_reg == ST_CLEAR);
        core_rd  = !in_clear && bus.read;
        core_wr  = !in_clear && bus.write;
        ld_ready = !in_clear && !bus.read && !bus.write;
        err_set  = in_clear ? (bus.read || bus.write) : (bus.read && bus.write);
        mem_re   = core_rd && !core_wr;

        if (in_clear) begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == '1) begin
                state_next = ST_READY;
            end
        end

        // A simultaneous read and write returns the data being written.
        if (core_rd && core_wr) begin
            rd_src_next  = SRC_WT;
            wt_data_next = bus.wr_data;
        end else if (core_rd) begin
            rd_src_next = SRC_MEM;
        end

        // Write-port priority: clear sequence, then core write, then host load.
        if (in_clear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_reg;
            mem_wdata = '0;
        end else if (core_wr) begin
            mem_we    = 1'b1;
            mem_waddr = bus.address;
            mem_wdata = bus.wr_data;
        end else if (bus.ld_valid && ld_ready) begin
            mem_we    = 1'b1;
            mem_waddr = bus.ld_addr;
            mem_wdata = bus.ld_data;
        end

        if (err_set) begin
            err_next = 1'b1;
        end else if (bus.err_clr) begin
            err_next = 1'b0;
        end else begin
            err_next = err_reg;
        end
    end

    mem_array #(
        .D_SIZE (D_SIZE),
        .A_SIZE (A_SIZE)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (bus.address),
        .rdata (mem_rdata)
    );

    // The selector is reset, so a read in flight at reset is discarded.
    always_comb begin
        case (rd_src_reg)
            SRC_MEM: bus.rd_data = mem_rdata;
            SRC_WT:  bus.rd_data = wt_data_reg;
            default: bus.rd_data = '0;
        endcase
    end

    assign bus.ld_ready  = ld_ready;
    assign bus.init_done = (state_reg == ST_READY);
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized and directed bench for data_memory_responder against a behavioural model.
module tb_data_memory_responder;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_responder_if #(.D_SIZE(DW), .A_SIZE(AW)) bus ();

    data_memory_responder #(
        .D_SIZE         (DW),
        .A_SIZE         (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rd;
    logic          m_err;
    bit            m_ready;
    int            m_clr_words;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd        = '0;
        m_err       = 1'b0;
        m_ready     = 1'b0;
        m_clr_words = 0;
    endtask

    // Applies one clock edge of the specified behaviour to the model.
    task automatic model_edge();
        int a;
        int la;
        a  = int'(bus.address);
        la = int'(bus.ld_addr);
        if (!m_ready) begin
            if (bus.read || bus.write) m_err = 1'b1;
            else if (bus.err_clr)      m_err = 1'b0;
            m_mem[m_clr_words] = '0;
            m_clr_words++;
            if (m_clr_words == DEPTH) m_ready = 1'b1;
        end else if (bus.read && bus.write) begin
            m_mem[a] = bus.wr_data;
            m_rd     = bus.wr_data;
            m_err    = 1'b1;
        end else begin
            if (bus.write) m_mem[a] = bus.wr_data;
            if (bus.read)  m_rd = m_mem[a];
            if (!bus.read && !bus.write && bus.ld_valid) m_mem[la] = bus.ld_data;
            if (bus.err_clr) m_err = 1'b0;
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic lv, input logic [AW-1:0] la,
                         input logic [DW-1:0] ld, input logic ec);
        bus.read     = r;
        bus.write    = w;
        bus.address  = a;
        bus.wr_data  = wd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        bus.ld_data  = ld;
        bus.err_clr  = ec;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // One clock: check the combinational ready, advance the model, check registered outputs.
    task automatic tick(input string tag);
        logic exp_ldr;
        @(negedge clk);
        exp_ldr = m_ready && !bus.read && !bus.write;
        check({tag, ".ld_ready"}, {31'd0, bus.ld_ready}, {31'd0, exp_ldr});
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".rd_data"}, bus.rd_data, m_rd);
        check({tag, ".err"}, {31'd0, bus.err}, {31'd0, m_err});
        check({tag, ".init_done"}, {31'd0, bus.init_done}, {31'd0, m_ready});
        $display("txn %-10s r=%0b w=%0b a=%0d wd=%08h lv=%0b la=%0d ec=%0b -> rd=%08h err=%0b init=%0b",
                 tag, bus.read, bus.write, bus.address, bus.wr_data, bus.ld_valid, bus.ld_addr,
                 bus.err_clr, bus.rd_data, bus.err, bus.init_done);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rd_data"}, bus.rd_data, '0);
        check({tag, ".err"}, {31'd0, bus.err}, 32'd0);
        check({tag, ".init_done"}, {31'd0, bus.init_done}, 32'd0);
        check({tag, ".ld_ready"}, {31'd0, bus.ld_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();
        idle();
        #2;
        check_reset_values("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clear sequence: init_done must rise exactly after 16 edges.
        done_at = -1;
        for (int c = 1; c <= DEPTH + 2; c++) begin
            tick("clear");
            if (bus.init_done && done_at < 0) done_at = c;
        end
        check("clear_len", done_at, DEPTH);

        drive(1'b1, 1'b0, 4'd7, '0, 1'b0, '0, '0, 1'b0);
        tick("rd7");
        idle();
        tick("hold");

        drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
        tick("load3");
        drive(1'b1, 1'b0, 4'd3, '0, 1'b0, '0, '0, 1'b0);
        tick("rd3");
        check("rd3_value", bus.rd_data, 32'hDEADBEEF);

        // Core traffic blocks the host even while ld_valid is high.
        drive(1'b0, 1'b1, 4'd5, 32'h12345678, 1'b1, 4'd5, 32'hBAD0BAD0, 1'b0);
        tick("wr5");
        drive(1'b1, 1'b0, 4'd5, '0, 1'b1, 4'd5, 32'hBAD0BAD0, 1'b0);
        tick("rd5");
        check("rd5_value", bus.rd_data, 32'h12345678);

        drive(1'b1, 1'b1, 4'd2, 32'hA5A5A5A5, 1'b0, '0, '0, 1'b0);
        tick("rw2");
        check("rw2_err", {31'd0, bus.err}, 32'd1);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        tick("errclr");
        drive(1'b1, 1'b0, 4'd2, '0, 1'b0, '0, '0, 1'b0);
        tick("rd2");
        check("rd2_value", bus.rd_data, 32'hA5A5A5A5);

        // Fill the array with random traffic.
        for (int i = 0; i < 150; i++) begin
            drive(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3), AW'($urandom),
                  $urandom, ($urandom_range(0, 1) == 1), AW'($urandom), $urandom,
                  ($urandom_range(0, 9) == 0));
            tick("rand");
        end

        // Reset mid-read, then again at clear count 8.
        drive(1'b1, 1'b0, 4'd5, '0, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_mid_read");
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) tick("clr_a");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_clr8");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'd9, '0, 1'b0, '0, '0, 1'b0);
        tick("rd_in_clr");
        check("rd_in_clr_err", {31'd0, bus.err}, 32'd1);
        idle();
        done_at = -1;
        for (int c = 2; c <= DEPTH + 2; c++) begin
            tick("clr_b");
            if (bus.init_done && done_at < 0) done_at = c;
        end
        check("clear_len_restart", done_at, DEPTH);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        tick("errclr2");

        // Whole array must read back as zero after the clear.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, AW'(i), '0, 1'b0, '0, '0, 1'b0);
            tick("rdzero");
        end

        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3), AW'($urandom),
                  $urandom, ($urandom_range(0, 1) == 1), AW'($urandom), $urandom,
                  ($urandom_range(0, 9) == 0));
            tick("rand2");
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
